stack64_ctrl: RTL and testbench
===============================

STACK64_CTRL -- requirements
Module: stack64_ctrl

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits and depth at 64 entries, matching a RAM64 storage array.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clear  input  1  synchronous flush; empties the stack and zeroes the high-water mark.
REQ-005 push_valid  input  1  push request.
REQ-006 push_data  input  16  word to push.
REQ-007 push_ready  output  1  push can be accepted this cycle.
REQ-008 pop_valid  output  1  stack non-empty; pop_data is valid.
REQ-009 pop_ready  input  1  consumer takes the top word.
REQ-010 pop_data  output  16  current top-of-stack word, combinational from ram_out.
REQ-011 count  output  7  occupancy, 0..64.
REQ-012 empty / full  output  1 each  count==0 / count==64.
REQ-013 high_water  output  7  maximum count reached since the last reset or clear.
REQ-014 ram_address  output  6  address to the RAM64 port.
REQ-015 ram_in  output  16  write data to RAM64.
REQ-016 ram_load  output  1  write enable to RAM64.
REQ-017 ram_out  input  16  RAM64 combinational read data.

Function
REQ-018 State: stack pointer sp (7 bits, equal to count) and high_water register; no other state.
REQ-019 push_fire = push_valid & push_ready; pop_fire = pop_valid & pop_ready.
REQ-020 pop_valid = !empty; push_ready = !full | (pop_ready & !empty). This is the only combinational ready path.
REQ-021 Push only: ram_address = sp[5:0], ram_in = push_data, ram_load = 1; sp increments at the edge.
REQ-022 Pop only: ram_address = sp-1, ram_load = 0; pop_data = ram_out; sp decrements at the edge.
REQ-023 Push and pop in the same cycle (requires non-empty): replace-top; ram_address = sp-1, ram_load = 1, ram_in = push_data, pop_data = old ram_out; sp unchanged.
REQ-024 Idle (no fire): ram_address = sp-1 when non-empty, else 0; ram_load = 0.
REQ-025 Push and pop when empty: only the push fires (pop_valid=0); behaviour per REQ-021.
REQ-026 Full: push alone is not accepted and count stays 64; push with pop is accepted as replace-top.
REQ-027 No wrap-around: sp never exceeds 64 or goes below 0; ram_address uses sp[5:0] for push and (sp-1)[5:0] otherwise.
REQ-028 high_water updates at the edge to max(high_water, next count).
REQ-029 Pop latency is zero: data is consumed in the cycle pop_fire is high. A pushed word is readable as pop_data from the next cycle.
REQ-030 clear has priority over push and pop: ram_load = 0, and at the edge sp = 0 and high_water = 0; push_ready and pop_valid follow REQ-020 from the pre-clear state.

Reset
REQ-031 While reset is high, ram_load SHALL be 0. After the edge, sp = 0, count = 0, high_water = 0, empty = 1, full = 0, pop_valid = 0 and push_ready = 1.
REQ-032 Reset has priority over clear, push and pop. Reset in mid-operation discards all occupancy, while RAM contents are left unmodified.
REQ-033 Outputs other than ram_out-derived pop_data SHALL be defined during and after reset; pop_data is don't-care while pop_valid = 0.

Verification
REQ-034 Push 0x1111, 0x2222, 0x3333, then pop three times -> pop_data 0x3333, 0x2222, 0x1111; count 3->0; high_water = 3; empty = 1.
REQ-035 Push 64 words 0x0000..0x003F -> full = 1, count = 64, push_ready = 0 with pop_ready = 0. A 65th push is held, count stays 64, and no ram_load occurs.
REQ-036 At full, push 0xBEEF with pop_ready = 1 -> pop_data = 0x003F that cycle, ram_load = 1 at address 63, count = 64. The next pop returns 0xBEEF.
REQ-037 Empty, assert push_valid and pop_ready together with 0x00AA -> pop_valid = 0, push accepted at address 0, count = 1, pop_data = 0x00AA next cycle.
REQ-038 Push 5 words, assert clear together with push_valid -> no ram_load, and next cycle count = 0, high_water = 0, empty = 1.
REQ-039 Push 10 words, assert reset for one cycle with pop_ready = 1 -> ram_load = 0, count = 0 after the edge. Subsequent push/pop of 0x1234 returns 0x1234.

Source files
------------

// File: rtl/stack64_ctrl.sv
// stack64_ctrl: 64-entry x 16-bit LIFO controller that drives an external
// RAM64 with a combinational read port. It tracks occupancy and a high-water mark.
module stack64_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push_valid,
    input  logic [15:0] push_data,
    output logic        push_ready,
    output logic        pop_valid,
    input  logic        pop_ready,
    output logic [15:0] pop_data,
    output logic [6:0]  count,
    output logic        empty,
    output logic        full,
    output logic [6:0]  high_water,
    output logic [5:0]  ram_address,
    output logic [15:0] ram_in,
    output logic        ram_load,
    input  logic [15:0] ram_out
);

    localparam int unsigned CW    = 7;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;

    logic [CW-1:0] sp_q, sp_d;
    logic [CW-1:0] hw_q, hw_d;
    logic          push_fire;
    logic          pop_fire;

    // Handshake, status and RAM port decode derived from the stack pointer
    always_comb begin
        empty      = (sp_q == CW'(0));
        full       = (sp_q == CW'(DEPTH));
        pop_valid  = !empty;
        push_ready = !full || (pop_ready && !empty);
        push_fire  = push_valid && push_ready;
        pop_fire   = pop_valid && pop_ready;

        count      = sp_q;
        high_water = hw_q;
        pop_data   = ram_out;
        ram_in     = push_data;
        ram_load   = push_fire && !reset && !clear;

        // A push without a pop writes above the top; everything else addresses the top
        if (push_fire && !pop_fire) begin
            ram_address = sp_q[AW-1:0];
        end else if (!empty) begin
            ram_address = sp_q[AW-1:0] - AW'(1);
        end else begin
            ram_address = '0;
        end
    end

    // Next stack pointer and high-water mark; reset and clear both flush
    always_comb begin
        sp_d = sp_q;
        hw_d = hw_q;
        if (reset || clear) begin
            sp_d = '0;
            hw_d = '0;
        end else begin
            if (push_fire && !pop_fire) begin
                sp_d = sp_q + CW'(1);
            end else if (pop_fire && !push_fire) begin
                sp_d = sp_q - CW'(1);
            end
            hw_d = (sp_d > hw_q) ? sp_d : hw_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
            hw_q <= '0;
        end else begin
            sp_q <= sp_d;
            hw_q <= hw_d;
        end
    end

endmodule

// File: tb/tb_stack64_ctrl.sv
// Directed self-checking bench for stack64_ctrl with a behavioural RAM64.
module tb_stack64_ctrl;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        push_valid;
    logic [15:0] push_data;
    logic        push_ready;
    logic        pop_valid;
    logic        pop_ready;
    logic [15:0] pop_data;
    logic [6:0]  count;
    logic        empty;
    logic        full;
    logic [6:0]  high_water;
    logic [5:0]  ram_address;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [15:0] ram_out;

    logic [15:0] mem [64];

    int checks;
    int errors;

    stack64_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .pop_valid   (pop_valid),
        .pop_ready   (pop_ready),
        .pop_data    (pop_data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .high_water  (high_water),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_out     (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM64: combinational read, synchronous write
    assign ram_out = mem[ram_address];
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [15:0] pd, input logic pr,
                         input logic clr, input logic rst);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        clear      = clr;
        reset      = rst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;

        // Reset with a push request pending: no RAM write allowed
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
        chk("rst_ram_load", 16'(ram_load), 16'h0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_count", 16'(count), 16'd0);
        chk("rst_hw", 16'(high_water), 16'd0);
        chk("rst_empty", 16'(empty), 16'h1);
        chk("rst_full", 16'(full), 16'h0);
        chk("rst_pop_valid", 16'(pop_valid), 16'h0);
        chk("rst_push_ready", 16'(push_ready), 16'h1);

        // Three pushes then three pops in LIFO order
        drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        chk("p1_addr", 16'(ram_address), 16'd0);
        chk("p1_load", 16'(ram_load), 16'h1);
        tick();
        drive(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        chk("p2_addr", 16'(ram_address), 16'd1);
        tick();
        drive(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        chk("p3_addr", 16'(ram_address), 16'd2);
        tick();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("l3_count", 16'(count), 16'd3);
        chk("pop1_data", pop_data, 16'h3333);
        chk("pop1_load", 16'(ram_load), 16'h0);
        tick();
        chk("pop2_data", pop_data, 16'h2222);
        chk("pop2_count", 16'(count), 16'd2);
        tick();
        chk("pop3_data", pop_data, 16'h1111);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("l3_end_count", 16'(count), 16'd0);
        chk("l3_hw", 16'(high_water), 16'd3);
        chk("l3_empty", 16'(empty), 16'h1);

        // Fill to 64 entries
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
            chk("fill_addr", 16'(ram_address), 16'(i));
            tick();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("full_flag", 16'(full), 16'h1);
        chk("full_count", 16'(count), 16'd64);
        chk("full_push_ready", 16'(push_ready), 16'h0);
        chk("full_hw", 16'(high_water), 16'd64);
        chk("full_top", pop_data, 16'h003F);
        // 65th push is held
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        chk("p65_ready", 16'(push_ready), 16'h0);
        chk("p65_load", 16'(ram_load), 16'h0);
        tick();
        chk("p65_count", 16'(count), 16'd64);

        // Replace-top at full
        drive(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        chk("rt_ready", 16'(push_ready), 16'h1);
        chk("rt_pop_data", pop_data, 16'h003F);
        chk("rt_load", 16'(ram_load), 16'h1);
        chk("rt_addr", 16'(ram_address), 16'd63);
        tick();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("rt_count", 16'(count), 16'd64);
        chk("rt_pop_new", pop_data, 16'hBEEF);
        tick();
        chk("rt_pop_next", pop_data, 16'h003E);
        chk("rt_after_count", 16'(count), 16'd63);

        // Clear alone flushes occupancy and high-water
        drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("clr_load", 16'(ram_load), 16'h0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("clr_count", 16'(count), 16'd0);
        chk("clr_hw", 16'(high_water), 16'd0);

        // Push and pop together while empty: only the push fires
        drive(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
        chk("ep_pop_valid", 16'(pop_valid), 16'h0);
        chk("ep_addr", 16'(ram_address), 16'd0);
        chk("ep_load", 16'(ram_load), 16'h1);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("ep_count", 16'(count), 16'd1);
        chk("ep_pop_valid2", 16'(pop_valid), 16'h1);
        chk("ep_data", pop_data, 16'h00AA);
        chk("ep_idle_addr", 16'(ram_address), 16'd0);

        // Five pushes, then clear with a push pending
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0500 + 16'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 16'h0555, 1'b0, 1'b1, 1'b0);
        chk("cp_count_pre", 16'(count), 16'd6);
        chk("cp_load", 16'(ram_load), 16'h0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("cp_count", 16'(count), 16'd0);
        chk("cp_hw", 16'(high_water), 16'd0);
        chk("cp_empty", 16'(empty), 16'h1);

        // Ten pushes, then reset mid-operation with a pop requested
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        chk("mr_hw_pre", 16'(high_water), 16'd10);
        chk("mr_load", 16'(ram_load), 16'h0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("mr_count", 16'(count), 16'd0);
        chk("mr_hw", 16'(high_water), 16'd0);
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        chk("mr_push_addr", 16'(ram_address), 16'd0);
        tick();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("mr_pop_data", pop_data, 16'h1234);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("mr_end_count", 16'(count), 16'd0);
        chk("mr_end_hw", 16'(high_water), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
